// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding, default geometry and data widths for the conv engine
package conv_pkg;
    typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_OUTPUT} state_t;
    localparam int N_DEF  = 8;
    localparam int F_DEF  = 4;
    localparam int DW_IN  = 8;
    localparam int DW_OUT = 18;
endpackage

// File: rtl/mod_counter.sv
// mod_counter: up-counter with synchronous clear, enable and terminal-count flag
module mod_counter
    import conv_pkg::*;
#(
    parameter int W   = 4,
    parameter int MAX = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_q,
    output logic         o_tc
);
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst)      o_q <= '0;
        else if (i_clr) o_q <= '0;
        else if (i_en)  o_q <= o_q + W'(1);
    assign o_tc = (o_q == W'(MAX));
endmodule

// File: rtl/conv_sequencer.sv
// conv_sequencer: load/compute/output control for the 8x4 conv datapath
// Drives memory addresses, write enables, accumulator clear/enable and the y handshake.
module conv_sequencer
    import conv_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int F    = F_DEF,
    parameter int LOGN = $clog2(N),
    parameter int LOGF = $clog2(F)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_valid_x,
    output logic            s_ready_x,
    input  logic            s_valid_f,
    output logic            s_ready_f,
    output logic [LOGN-1:0] addr_x,
    output logic            wr_en_x,
    output logic [LOGF-1:0] addr_f,
    output logic            wr_en_f,
    output logic            clr_acc,
    output logic            en_acc,
    output logic            m_valid_y,
    input  logic            m_ready_y
);
    localparam int WX = LOGN + 1;
    localparam int WF = LOGF + 1;

    state_t          r_state;
    logic [WX-1:0]   w_wx, w_k;
    logic [WF-1:0]   w_wf, w_j;
    logic            w_wx_tc, w_wf_tc, w_k_tc, w_j_tc;
    logic            w_load, w_comp, w_out;
    logic            w_x_done, w_f_done, w_hs, w_batch_end;
    logic [LOGN-1:0] w_rd_x;

    assign w_load = (r_state == S_LOAD);
    assign w_comp = (r_state == S_COMPUTE);
    assign w_out  = (r_state == S_OUTPUT);

    // ready is forced low for the whole time reset is held, not just after the first edge
    assign s_ready_x = ~reset & w_load & ~w_wx_tc;
    assign s_ready_f = ~reset & w_load & ~w_wf_tc;
    assign wr_en_x   = s_valid_x & s_ready_x;
    assign wr_en_f   = s_valid_f & s_ready_f;

    assign w_x_done    = w_wx_tc | (wr_en_x & (w_wx == WX'(N - 1)));
    assign w_f_done    = w_wf_tc | (wr_en_f & (w_wf == WF'(F - 1)));
    assign w_hs        = w_out & m_ready_y;
    assign w_batch_end = w_hs & w_k_tc;

    mod_counter #(.W(WX), .MAX(N)) u_wx (
        .i_clk(clk), .i_rst(reset), .i_clr(w_batch_end), .i_en(wr_en_x), .o_q(w_wx), .o_tc(w_wx_tc)
    );
    mod_counter #(.W(WF), .MAX(F)) u_wf (
        .i_clk(clk), .i_rst(reset), .i_clr(w_batch_end), .i_en(wr_en_f), .o_q(w_wf), .o_tc(w_wf_tc)
    );
    mod_counter #(.W(WX), .MAX(N - F)) u_k (
        .i_clk(clk), .i_rst(reset), .i_clr(w_batch_end), .i_en(w_hs & ~w_k_tc), .o_q(w_k), .o_tc(w_k_tc)
    );
    mod_counter #(.W(WF), .MAX(F)) u_j (
        .i_clk(clk), .i_rst(reset), .i_clr(~w_comp), .i_en(w_comp & ~w_j_tc), .o_q(w_j), .o_tc(w_j_tc)
    );

    // j runs one past the last tap so the final product lands after the 1-cycle memory read
    assign w_rd_x    = w_k[LOGN-1:0] + LOGN'(w_j);
    assign addr_x    = w_load ? w_wx[LOGN-1:0] : w_rd_x;
    assign addr_f    = w_load ? w_wf[LOGF-1:0] : w_j[LOGF-1:0];
    assign clr_acc   = w_comp & (w_j == '0);
    assign en_acc    = w_comp & (w_j != '0);
    assign m_valid_y = w_out;

    always_ff @(posedge clk or posedge reset)
        if (reset) r_state <= S_LOAD;
        else case (r_state)
            S_LOAD:    if (w_x_done & w_f_done) r_state <= S_COMPUTE;
            S_COMPUTE: if (w_j_tc) r_state <= S_OUTPUT;
            S_OUTPUT:  if (m_ready_y) r_state <= w_k_tc ? S_LOAD : S_COMPUTE;
            default:   r_state <= S_LOAD;
        endcase
endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: directed bench with behavioural memories and MAC around the sequencer
module tb_conv_sequencer;
    localparam int N = 8;
    localparam int F = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic s_valid_x = 1'b0, s_valid_f = 1'b0, m_ready_y = 1'b0;
    logic s_ready_x, s_ready_f, wr_en_x, wr_en_f, clr_acc, en_acc, m_valid_y;
    logic [2:0] addr_x;
    logic [1:0] addr_f;

    logic signed [7:0]  d_x, d_f, rx, rf;
    logic signed [7:0]  mx [N];
    logic signed [7:0]  mf [F];
    logic signed [15:0] prod;
    logic signed [17:0] acc;
    logic signed [7:0]  lx [N];
    logic signed [7:0]  lf [F];
    logic signed [17:0] ey [N-F+1];
    logic signed [17:0] gy [N-F+1];
    logic signed [17:0] uy [N-F+1];
    int n_chk = 0, n_err = 0, n;

    always #5 clk = ~clk;

    conv_sequencer dut (
        .clk(clk), .reset(reset),
        .s_valid_x(s_valid_x), .s_ready_x(s_ready_x),
        .s_valid_f(s_valid_f), .s_ready_f(s_ready_f),
        .addr_x(addr_x), .wr_en_x(wr_en_x),
        .addr_f(addr_f), .wr_en_f(wr_en_f),
        .clr_acc(clr_acc), .en_acc(en_acc),
        .m_valid_y(m_valid_y), .m_ready_y(m_ready_y)
    );

    assign prod = rx * rf;

    always @(posedge clk) begin
        if (wr_en_x) mx[addr_x] <= d_x;
        if (wr_en_f) mf[addr_f] <= d_f;
        rx <= mx[addr_x];
        rf <= mf[addr_f];
    end

    always @(posedge clk or posedge reset)
        if (reset)        acc <= '0;
        else if (clr_acc) acc <= '0;
        else if (en_acc)  acc <= acc + 18'(prod);

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!m_valid_y && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("valid_timeout", m_valid_y, 1);
    endtask

    task automatic load(input bit f_first, input bit gaps);
        int ix = 0, fx = 0, cyc = 0, spur = 0;
        bit hx, hf, seen = 0;
        while ((ix < N || fx < F) && cyc < 200) begin
            if (f_first && fx == F && !seen) begin
                chk("ready_f_after_full", s_ready_f, 0);
                chk("ready_x_while_f_full", s_ready_x, 1);
                seen = 1;
            end
            s_valid_f = (fx < F);
            s_valid_x = (ix < N) && !(f_first && fx < F) && (!gaps || $urandom_range(0, 1) == 1);
            d_x = s_valid_x ? lx[ix] : 'x;
            d_f = s_valid_f ? lf[fx] : 'x;
            #1;
            hx = s_valid_x & s_ready_x;
            hf = s_valid_f & s_ready_f;
            if (m_valid_y) spur++;
            @(posedge clk); #1;
            ix += int'(hx);
            fx += int'(hf);
            cyc++;
        end
        s_valid_x = 0; s_valid_f = 0; d_x = 'x; d_f = 'x;
        chk("load_done", int'(cyc < 200), 1);
        chk("spurious_valid", spur, 0);
    endtask

    task automatic collect(input int k0);
        int c;
        for (int k = k0; k <= N - F; k++) begin
            wait_valid(c);
            chk($sformatf("latency_k%0d", k), c, F + 1);
            chk($sformatf("y_k%0d", k), acc, ey[k]);
            @(posedge clk); #1;
        end
        chk("back_to_load_ready_x", s_ready_x, 1);
        chk("back_to_load_addr_x", addr_x, 0);
    endtask

    initial begin
        d_x = 'x; d_f = 'x;
        gy = '{-18'sd2800, 18'sd3600, 18'sd400, 18'sd1600, 18'sd2800};
        uy = '{18'sd10, 18'sd14, 18'sd18, 18'sd22, 18'sd26};
        #3;
        chk("rst_ready_x", s_ready_x, 0);
        chk("rst_ready_f", s_ready_f, 0);
        chk("rst_valid_y", m_valid_y, 0);
        chk("rst_en_acc", en_acc, 0);
        chk("rst_clr_acc", clr_acc, 0);
        chk("rst_addr_x", addr_x, 0);
        chk("rst_addr_f", addr_f, 0);
        #9 reset = 0;
        #1;
        chk("rel_ready_x", s_ready_x, 1);
        chk("rel_ready_f", s_ready_f, 1);
        @(posedge clk); #1;

        // golden batch with backpressure at y[1] and a traced k=2
        m_ready_y = 1;
        lx = '{8'sd10, -8'sd20, 8'sd30, -8'sd40, 8'sd50, 8'sd60, 8'sd70, 8'sd80};
        lf = '{8'sd10, 8'sd20, -8'sd30, 8'sd40};
        load(0, 0);
        chk("first_clr", clr_acc, 1);
        chk("compute_ready_x", s_ready_x, 0);
        wait_valid(n);
        chk("first_latency", n, F + 1);
        chk("y0", acc, gy[0]);
        @(posedge clk); #1;
        m_ready_y = 0;
        wait_valid(n);
        chk("y1_latency", n, F + 1);
        chk("y1", acc, gy[1]);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("bp_valid", m_valid_y, 1);
            chk("bp_y", acc, gy[1]);
            chk("bp_en", en_acc, 0);
        end
        m_ready_y = 1;
        s_valid_x = 1; s_valid_f = 1; d_x = 8'sd99; d_f = 8'sd99;
        @(posedge clk); #1;
        chk("compute_wr_en_x", wr_en_x, 0);
        chk("compute_wr_en_f", wr_en_f, 0);
        for (int jj = 0; jj <= F; jj++) begin
            if (jj < F) begin
                chk($sformatf("trace_addr_x_%0d", jj), addr_x, 2 + jj);
                chk($sformatf("trace_addr_f_%0d", jj), addr_f, jj);
            end
            chk($sformatf("trace_clr_%0d", jj), clr_acc, int'(jj == 0));
            chk($sformatf("trace_en_%0d", jj), en_acc, int'(jj != 0));
            @(posedge clk); #1;
        end
        s_valid_x = 0; s_valid_f = 0; d_x = 'x; d_f = 'x;
        chk("y2_valid", m_valid_y, 1);
        chk("y2_en", en_acc, 0);
        chk("y2", acc, gy[2]);
        @(posedge clk); #1;
        ey = gy;
        collect(3);

        // f first, then x with random gaps
        lx = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd6, 8'sd7, 8'sd8};
        lf = '{8'sd1, 8'sd1, 8'sd1, 8'sd1};
        load(1, 1);
        ey = uy;
        collect(0);

        // reset in the middle of a compute pass, then a clean golden rerun
        lx = '{8'sd10, -8'sd20, 8'sd30, -8'sd40, 8'sd50, 8'sd60, 8'sd70, 8'sd80};
        lf = '{8'sd10, 8'sd20, -8'sd30, 8'sd40};
        load(0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_en_before_rst", en_acc, 1);
        #3 reset = 1;
        #1;
        chk("mid_rst_en", en_acc, 0);
        chk("mid_rst_clr", clr_acc, 0);
        chk("mid_rst_valid", m_valid_y, 0);
        chk("mid_rst_ready_x", s_ready_x, 0);
        chk("mid_rst_addr_x", addr_x, 0);
        chk("mid_rst_addr_f", addr_f, 0);
        #2 reset = 0;
        @(posedge clk); #1;
        chk("post_rst_ready_f", s_ready_f, 1);
        load(0, 0);
        ey = gy;
        collect(0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/conv_sequencer.md
# conv_sequencer

Control FSM that sequences one convolution pass of the 8-by-4 conv datapath. It owns both operand memories' address, write-enable and input handshakes, plus the accumulator's enable/clear, and it drives the output-valid handshake. It sits between the AXI-style stream inputs/outputs and the existing memory + multiply-accumulate datapath, which becomes pure datapath with no control of its own.

## Interface
- N, default 8: x vector length (x memory depth).
- F, default 4: filter length (f memory depth). Requires F ≤ N.
- LOGN, default $clog2(N): x address width.
- LOGF, default $clog2(F): f address width.
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high. Clears all state immediately.
- s_valid_x  in  1  x input word valid.
- s_ready_x  out  1  block accepts an x word this cycle.
- s_valid_f  in  1  f input word valid.
- s_ready_f  out  1  block accepts an f word this cycle.
- addr_x  out  LOGN  x memory address (write address in LOAD, read address otherwise).
- wr_en_x  out  1  x memory write enable; equals s_valid_x & s_ready_x.
- addr_f  out  LOGF  f memory address (same muxing rule as addr_x).
- wr_en_f  out  1  f memory write enable; equals s_valid_f & s_ready_f.
- clr_acc  out  1  accumulator synchronous clear.
- en_acc  out  1  accumulator add-enable; adds the product of the memory read data.
- m_valid_y  out  1  accumulator output holds a finished y.
- m_ready_y  in  1  downstream consumer accepts y.

## Operation
- States: S_LOAD, S_COMPUTE, S_OUTPUT. The reset state is S_LOAD with every counter at 0.
- S_LOAD:
  - s_ready_x = (wx < N); s_ready_f = (wf < F).
  - Each accepted word writes at address wx or wf, and that counter then increments.
  - x and f load independently; simultaneous accepts are legal.
  - Go to S_COMPUTE on the edge where both memories are full, including the edge that carries the final write(s).
- S_COMPUTE, for output index k (0..N-F), uses step counter j = 0..F:
  - For j < F: addr_x = k+j, addr_f = j.
  - clr_acc = 1 only at j = 0.
  - en_acc = 1 for j = 1..F, which matches the memories' 1-cycle read latency.
  - At j = F, go to S_OUTPUT.
- S_OUTPUT:
  - m_valid_y = 1, and it stays asserted with the accumulator frozen (en_acc = 0, clr_acc = 0) until m_ready_y is seen.
  - On handshake with k < N-F: k increments and the FSM returns to S_COMPUTE with j = 0.
  - On handshake with k = N-F: clear wx, wf and k, then go to S_LOAD.
- s_ready_x and s_ready_f are 0 outside S_LOAD. A new batch never overlaps computation.
- wr_en_x and wr_en_f are never asserted outside S_LOAD.
- Arithmetic: the datapath computes y[k] = Σ_{j<F} x[k+j]·f[j] as 8-bit signed inputs producing an 18-bit signed result. Width handling belongs to the datapath; this block only guarantees the exact F enables after each clear.

## Timing
- Reset values:
  - s_ready_x = 0 and s_ready_f = 0 while reset is high; both are 1 from the first cycle after deassertion.
  - m_valid_y = 0, en_acc = 0, clr_acc = 0, wr_en_x = 0, wr_en_f = 0.
  - addr_x = 0 and addr_f = 0.
- Latency from entering S_COMPUTE to m_valid_y is F+1 cycles.
- With m_ready_y held high, each output occupies F+2 cycles.
- With continuous inputs, N=8 and F=4: 8 load cycles + 5 outputs × 6 cycles = 38 cycles per batch.
- m_valid_y is registered and is never deasserted before the handshake.
- The block accepts m_ready_y asserted before m_valid_y; the handshake completes in the first cycle m_valid_y is high.
- Reset asserted mid-batch discards partial loads and results. The next batch starts from address 0.
- Invalid input data (X) while valid is low must never reach the memories: wr_en stays 0.

## Structure
- Shared package conv_pkg holds:
  - the state_t enum {S_LOAD, S_COMPUTE, S_OUTPUT};
  - default N and F constants;
  - the data widths: 8-bit input, 18-bit output.
- One sub-module, mod_counter, is a parameterised up-counter with clear, enable and terminal-count flag. It is instantiated for wx, wf, k and j.
- The FSM and the address/handshake muxing live in conv_sequencer itself.

## Test plan
- **Reset:** assert reset asynchronously mid-cycle -> all outputs go to the reset values immediately; after release, s_ready_x = 1 and s_ready_f = 1.
- **Golden batch:** x={10,-20,30,-40,50,60,70,80}, f={10,20,-30,40}, continuous valid/ready, sequencer wired to two memories plus the MAC -> y = {-2800, 3600, 400, 1600, 2800}, with m_valid_y first rising 5 cycles after load completes.
- **Control trace:** for k=2, observe addr_x = 2,3,4,5 and addr_f = 0,1,2,3 on consecutive cycles; clr_acc is high on the first cycle only; en_acc is high for exactly 4 cycles, lagging the addresses by 1.
- **Backpressure:** hold m_ready_y = 0 for 10 cycles at y[1] -> m_valid_y stays 1, y stays 3600 and en_acc stays 0; the handshake then advances to y[2].
- **Unbalanced loading:**
  - Load f fully first, then x with random gaps; s_ready_f must be 0 after 4 writes.
  - Second batch: x={1..8} with all-ones f -> y = {10,14,18,22,26}.
- **Mid-batch reset:** reset during S_COMPUTE, then reload the golden batch -> the full correct sequence is produced, with no spurious m_valid_y.
